// File: rtl/flag_if.sv
// Bundle between the EX/ID pipeline stages and the flag unit.
// Holds the pipeline inputs and the flag/stall outputs read by the next-PC logic.
interface flag_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   id_valid;
  logic                   id_is_branch;
  logic                   ex_valid;
  logic [3:0]             ex_opcode;
  logic [15:0]            ex_result;
  logic                   ex_ovfl;
  logic                   pipe_stall;
  logic                   flush;
  logic [2:0]             flags;
  logic                   flag_wr;
  logic                   br_stall;
  logic                   halted;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_is_branch, ex_valid, ex_opcode, ex_result, ex_ovfl,
           pipe_stall, flush,
    input  flags, flag_wr, br_stall, halted, stall_cnt
  );

  modport slave (
    input  id_valid, id_is_branch, ex_valid, ex_opcode, ex_result, ex_ovfl,
           pipe_stall, flush,
    output flags, flag_wr, br_stall, halted, stall_cnt
  );
endinterface

// File: rtl/flag_unit.sv
// Branch-condition flag producer: captures {N,V,Z} from retiring EX results,
// raises the branch stall while a flag writer sits in EX, and freezes after HLT.
//
// state    | meaning
// S_RUN    | normal operation, retiring writers update flags
// S_HALTED | HLT has retired; flags, flag_wr and stall_cnt frozen until reset
module flag_unit #(
  parameter int STALL_CNT_W = 16
) (
  input logic   clk,
  input logic   rst_n,
  flag_if.slave fu
);
  typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = 1;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_flags;
  logic [2:0]             w_flags_nxt;
  logic                   r_flag_wr;
  logic                   w_flag_wr_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   w_full_wr;
  logic                   w_z_wr;
  logic                   w_writer;
  logic                   w_halted;
  logic                   w_ex_ret;
  logic                   w_br_stall;

  always_comb begin
    w_full_wr = 1'b0;
    w_z_wr    = 1'b0;
    case (fu.ex_opcode)
      4'b0000, 4'b0001:                   w_full_wr = 1'b1;
      4'b0010, 4'b0100, 4'b0101, 4'b0110: w_z_wr    = 1'b1;
      default: ;
    endcase
  end

  assign w_writer = w_full_wr | w_z_wr;
  assign w_halted = (r_state == S_HALTED);
  assign w_ex_ret = fu.ex_valid & ~fu.flush & ~fu.pipe_stall & ~w_halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RUN;
      r_flags   <= 3'b000;
      r_flag_wr <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_flags   <= w_flags_nxt;
      r_flag_wr <= w_flag_wr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_flags_nxt   = r_flags;
    w_flag_wr_nxt = 1'b0;
    w_br_stall    = 1'b0;
    case (r_state)
      S_RUN: begin
        // pipe_stall deliberately does not mask the stall: the writer is still in EX
        w_br_stall = fu.id_valid & fu.id_is_branch & fu.ex_valid & ~fu.flush & w_writer;
        if (w_ex_ret && w_writer) begin
          w_flag_wr_nxt  = 1'b1;
          w_flags_nxt[0] = (fu.ex_result == 16'h0000);
          if (w_full_wr) w_flags_nxt[2:1] = {fu.ex_result[15], fu.ex_ovfl};
        end
        if (w_ex_ret && (fu.ex_opcode == 4'b1111)) w_state_nxt = S_HALTED;
      end
      S_HALTED: ;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_br_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign fu.flags     = r_flags;
  assign fu.flag_wr   = r_flag_wr;
  assign fu.br_stall  = w_br_stall;
  assign fu.halted    = w_halted;
  assign fu.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_flag_unit.sv
// Self-checking bench for flag_unit: directed scenarios then randomized traffic
// against a behavioural flag model; a second 2-bit-counter instance checks saturation.
module tb_flag_unit;
  logic clk;
  logic rst_n;

  flag_if #(.STALL_CNT_W(16)) fif ();
  flag_if #(.STALL_CNT_W(2))  fif2 ();

  assign fif2.id_valid     = fif.id_valid;
  assign fif2.id_is_branch = fif.id_is_branch;
  assign fif2.ex_valid     = fif.ex_valid;
  assign fif2.ex_opcode    = fif.ex_opcode;
  assign fif2.ex_result    = fif.ex_result;
  assign fif2.ex_ovfl      = fif.ex_ovfl;
  assign fif2.pipe_stall   = fif.pipe_stall;
  assign fif2.flush        = fif.flush;

  flag_unit #(.STALL_CNT_W(16)) u_dut  (.clk(clk), .rst_n(rst_n), .fu(fif));
  flag_unit #(.STALL_CNT_W(2))  u_dut2 (.clk(clk), .rst_n(rst_n), .fu(fif2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic m_n, m_v, m_z, m_wr, m_halted;
  int   m_cnt, m_cnt2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_writer(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
  endfunction

  task automatic drive(input logic idv, input logic idb, input logic exv, input logic [3:0] op,
                       input logic [15:0] res, input logic ov, input logic ps, input logic fl);
    fif.id_valid = idv; fif.id_is_branch = idb; fif.ex_valid = exv; fif.ex_opcode = op;
    fif.ex_result = res; fif.ex_ovfl = ov; fif.pipe_stall = ps; fif.flush = fl;
  endtask

  task automatic model_reset();
    m_n = 0; m_v = 0; m_z = 0; m_wr = 0; m_halted = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".flags"},     fif.flags, {m_n, m_v, m_z});
    check({tag, ".flag_wr"},   fif.flag_wr, m_wr);
    check({tag, ".halted"},    fif.halted, m_halted);
    check({tag, ".stall_cnt"}, fif.stall_cnt, m_cnt);
    check({tag, ".stall_cnt2"}, fif2.stall_cnt, m_cnt2);
  endtask

  // one clock: check combinational stall, advance model, check registered outputs
  task automatic cycle(input string tag);
    bit exp_br, ret;
    exp_br = fif.id_valid && fif.id_is_branch && fif.ex_valid && !fif.flush &&
             is_writer(fif.ex_opcode) && !m_halted;
    ret    = fif.ex_valid && !fif.flush && !fif.pipe_stall && !m_halted;
    #1;
    check({tag, ".br_stall"}, fif.br_stall, exp_br);
    m_wr = 0;
    if (ret && is_writer(fif.ex_opcode)) begin
      m_wr = 1;
      m_z  = (fif.ex_result == 16'h0000);
      if (fif.ex_opcode < 4'd2) begin
        m_n = fif.ex_result[15];
        m_v = fif.ex_ovfl;
      end
    end
    if (ret && fif.ex_opcode == 4'hF) m_halted = 1;
    if (exp_br) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic bubble();
    drive(0, 0, 0, 4'h3, 16'h0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs(tag);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int halt_age;
    rst_n = 1'b0;
    bubble();
    model_reset();
    #12;
    check_regs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full write: N=1, V=1, Z=0
    drive(0, 0, 1, 4'h0, 16'h8000, 1, 0, 0); cycle("add_nv");
    check("add_nv.direct", fif.flags, 3'b110);
    // ADD zero, XOR nonzero, ADD neg+ovfl, SLL zero
    drive(0, 0, 1, 4'h0, 16'h0000, 0, 0, 0); cycle("add_z");
    drive(0, 0, 1, 4'h2, 16'h0005, 0, 0, 0); cycle("xor_nz");
    check("xor_nz.direct", fif.flags, 3'b000);
    drive(0, 0, 1, 4'h0, 16'hFFFF, 1, 0, 0); cycle("add_neg");
    drive(0, 0, 1, 4'h4, 16'h0000, 0, 0, 0); cycle("sll_z");
    check("sll_z.direct", fif.flags, 3'b111);

    // branch vs SUB in EX, then bubble
    do_reset("rst1");
    drive(1, 1, 1, 4'h1, 16'h8000, 0, 0, 0); cycle("br_sub");
    check("br_sub.cnt", fif.stall_cnt, 1);
    bubble(); fif.id_valid = 1; fif.id_is_branch = 1; cycle("br_after");
    check("br_after.flags", fif.flags, 3'b100);

    // same-cycle flush kills write and stall
    drive(1, 1, 1, 4'h1, 16'h0000, 1, 0, 1); cycle("flush");
    check("flush.wr", fif.flag_wr, 0);

    // pipe_stall held: 4 stall cycles, one write; 5 cycles saturates the 2-bit counter
    do_reset("rst2");
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 4'h1, 16'h0000, 0, 1, 0); cycle("pstall");
    end
    check("pstall.noupd", fif.flags, 3'b000);
    drive(1, 1, 1, 4'h1, 16'h0000, 0, 0, 0); cycle("pstall_rel");
    check("pstall.cnt", fif.stall_cnt, 5);
    check("pstall.sat2", fif2.stall_cnt, 3);

    // HLT then frozen behaviour
    drive(1, 1, 1, 4'hF, 16'h0000, 0, 0, 0); cycle("hlt");
    drive(0, 0, 1, 4'h0, 16'h8000, 1, 0, 0); cycle("halt_add");
    drive(1, 1, 1, 4'h0, 16'h0000, 0, 0, 0); cycle("halt_br");
    check("halt.hold", fif.flags, 3'b001);

    // reset mid-stall loses the pending write
    do_reset("rst3");
    drive(1, 1, 1, 4'h0, 16'hFFFF, 1, 0, 0); #2;
    do_reset("rst_mid");
    bubble(); cycle("rst_mid.after");

    // randomized traffic
    halt_age = 0;
    for (int i = 0; i < 600; i++) begin
      logic [3:0]  op;
      logic [15:0] res;
      op  = 4'($urandom_range(0, 15));
      if (op == 4'hF && ($urandom % 4) != 0) op = 4'h0;
      res = (($urandom % 4) == 0) ? 16'h0000 : 16'($urandom);
      drive(1'($urandom % 2), 1'($urandom % 2), 1'(($urandom % 4) != 0), op, res,
            1'($urandom % 2), 1'(($urandom % 4) == 0), 1'(($urandom % 6) == 0));
      cycle("rand");
      halt_age = m_halted ? halt_age + 1 : 0;
      if (halt_age > 6 || ($urandom % 60) == 0) begin
        do_reset("rand_rst");
        halt_age = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/flag_unit.md
# flag_unit

Producer side of the branch-condition flags: captures N, V and Z from the EX-stage ALU result under opcode-dependent update rules and holds them for branch resolution in ID. It also raises a one-cycle branch stall when a flag-writing instruction is still in EX. After an HLT retires in EX, the flags are frozen. It sits between the ALU/EX pipeline register and the next-PC logic, and drives that logic's 3-bit flag input.

## Interface
- STALL_CNT_W, 16, width of saturating branch-stall counter
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- id_valid  input  1  ID stage holds a valid instruction
- id_is_branch  input  1  ID instruction is B or BR (reads flags)
- ex_valid  input  1  EX stage holds a valid instruction
- ex_opcode  input  4  opcode of EX instruction
- ex_result  input  16  ALU result of EX instruction
- ex_ovfl  input  1  signed overflow from EX adder
- pipe_stall  input  1  pipeline frozen this cycle; no EX retirement
- flush  input  1  kill EX instruction this cycle
- flags  output  3  registered {N,V,Z}; bit2=N, bit1=V, bit0=Z
- flag_wr  output  1  registered pulse: flags changed by a retirement last cycle
- br_stall  output  1  combinational: hold ID/IF this cycle
- halted  output  1  registered: HLT has retired
- stall_cnt  output  STALL_CNT_W  saturating count of br_stall cycles

## Operation
- Retire condition: ex_ret = ex_valid & ~flush & ~pipe_stall & ~halted.
- Opcode classes:
  - ADD 0000, SUB 0001: write N, V, Z.
  - XOR 0010, SLL 0100, SRA 0101, ROR 0110: write Z only; N and V hold.
  - All other opcodes (RED, PADDSB, LW, SW, LLB, LHB, B, BR, PCS) write nothing.
  - HLT 1111: writes nothing, sets halted.
- Flag values:
  - Z = (ex_result == 16'h0000).
  - N = ex_result[15].
  - V = ex_ovfl.
- writer = opcode is in the full-write or Z-only class.
- State machine, two states:
  - RUN: on ex_ret with writer, update flags as above.
  - RUN → HALTED: on ex_ret with opcode 1111.
  - HALTED: flags, flag_wr (held 0) and stall_cnt frozen; br_stall forced 0; exit only by reset.
- br_stall = id_valid & id_is_branch & ex_valid & ~flush & writer(ex_opcode) & ~halted.
  - pipe_stall does not mask br_stall; the EX writer retires on the first cycle pipe_stall is low.
  - A non-writer in EX never stalls.
- stall_cnt increments by 1 each cycle br_stall=1 and saturates at all-ones.
- flag_wr = 1 in the cycle after any ex_ret with writer, even if the new value equals the old value.

## Timing
- Reset values (asynchronous, rst_n low): flags=3'b000, flag_wr=0, halted=0, stall_cnt=0, state RUN. br_stall follows its equation; it is 0 whenever ex_valid=0.
- Flag latency: an EX writer in cycle t is visible on flags from cycle t+1. A branch stalled in t reads the new flags in t+1.
- Back-to-back writers: each retirement overwrites in order. Z-only writers preserve N and V from the prior full writer.
- Same-cycle flush and writer: no update, no stall.
- pipe_stall=1: no update; br_stall may remain high across multiple cycles, and each cycle counts.
- Reset asserted mid-stall: all outputs return to reset values immediately. A pending EX write is lost.
- HLT in EX with a branch in ID: no stall, since HLT is not a writer; halted rises the next cycle.

## Test plan
- Reset, then ADD with ex_result=16'h8000, ex_ovfl=1 → next cycle flags=3'b110, flag_wr=1.
- ADD with result 0, ovfl 0 (flags 3'b001), then XOR with result 16'h0005 → flags=3'b000; then ADD with result 16'hFFFF, ovfl=1 (flags 3'b110), then SLL with result 0 → flags=3'b111.
- Branch in ID with SUB in EX → br_stall=1 that cycle, stall_cnt=1. Next cycle, with EX bubble, br_stall=0 and flags reflect the SUB.
- SUB in EX with flush=1 and branch in ID → br_stall=0, flags unchanged, flag_wr=0 next cycle.
- SUB in EX, branch in ID, pipe_stall=1 for 3 cycles → br_stall high 4 cycles, stall_cnt=4, flags update only after the cycle pipe_stall drops.
- HLT retires → halted=1 next cycle. A subsequent ADD with result 0 leaves flags unchanged, and a branch plus ADD gives br_stall=0. Asserting rst_n low mid-run clears all outputs asynchronously. With STALL_CNT_W=2 and 5 stall cycles, stall_cnt=3 (saturates).
